// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg
// Shared types and elaboration-time helpers for the LED pattern generator.
//   mode_e          : per-channel output mode (OFF/ON/BLINK/PWM), 2 bits.
//   presc_terminal  : last prescaler count value (CLK_HZ/TICK_HZ - 1).
//   presc_width     : bits needed to hold the prescaler count.
//   ch_width        : width of the channel select field (at least 1 bit).
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_e;

    function automatic int unsigned presc_terminal(input int unsigned clk_hz,
                                                   input int unsigned tick_hz);
        return (clk_hz / tick_hz) - 1;
    endfunction

    function automatic int unsigned presc_width(input int unsigned clk_hz,
                                                input int unsigned tick_hz);
        int unsigned term;
        term = presc_terminal(clk_hz, tick_hz);
        return (term < 1) ? 1 : $clog2(term + 1);
    endfunction

    function automatic int unsigned ch_width(input int unsigned n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/led_pattern_gen_channel.sv
// led_channel
// One LED channel: configuration registers, blink tick counter, phase bit
// and the registered output mux.
//   clk, rst   : clock, asynchronous active-high reset
//   tick       : one-cycle prescaler pulse
//   pwm_cnt    : shared free-running PWM counter
//   clear      : synchronous clear of counter and phase (phase alignment)
//   we         : decoded write strobe for this channel
//   cfg_mode/cfg_period/cfg_duty : configuration loaded when we is high
//   led        : registered LED drive
module led_channel
    import led_pattern_pkg::*;
#(
    parameter int unsigned PER_W      = 16,
    parameter int unsigned DUTY_W     = 8,
    parameter int unsigned RST_PERIOD = 500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [DUTY_W-1:0] pwm_cnt,
    input  logic              clear,
    input  logic              we,
    input  mode_e             cfg_mode,
    input  logic [PER_W-1:0]  cfg_period,
    input  logic [DUTY_W-1:0] cfg_duty,
    output logic              led
);

    mode_e             mode;
    logic [PER_W-1:0]  period;
    logic [DUTY_W-1:0] duty;
    logic [PER_W-1:0]  counter;
    logic              phase;

    logic [PER_W-1:0]  last_cnt;
    logic              led_next;

    // A period of 0 behaves as 1, so the last count is 0 in both cases.
    always_comb begin
        last_cnt = '0;
        if (period != '0) begin
            last_cnt = period - PER_W'(1);
        end
    end

    always_comb begin
        led_next = 1'b0;
        unique case (mode)
            MODE_OFF:   led_next = 1'b0;
            MODE_ON:    led_next = 1'b1;
            MODE_BLINK: led_next = phase;
            MODE_PWM:   led_next = (pwm_cnt < duty);
            default:    led_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode    <= MODE_OFF;
            period  <= PER_W'(RST_PERIOD);
            duty    <= '0;
            counter <= '0;
            phase   <= 1'b0;
            led     <= 1'b0;
        end else begin
            if (we) begin
                mode   <= cfg_mode;
                period <= cfg_period;
                duty   <= cfg_duty;
            end

            // A write or a restart always wins over a coincident tick.
            if (we || clear || (mode != MODE_BLINK)) begin
                counter <= '0;
                phase   <= 1'b0;
            end else if (tick) begin
                if (counter >= last_cnt) begin
                    counter <= '0;
                    phase   <= ~phase;
                end else begin
                    counter <= counter + PER_W'(1);
                end
            end

            led <= led_next;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen
// Multi-channel LED driver with a shared millisecond-style prescaler and a
// shared PWM counter. Each channel is OFF/ON/BLINK/PWM, set at runtime.
//   clk, rst      : board clock, asynchronous active-high reset
//   cfg_we        : single-cycle config write strobe
//   cfg_ch        : target channel (writes to channels >= N_CH are dropped)
//   cfg_mode      : 0=OFF 1=ON 2=BLINK 3=PWM
//   cfg_period    : blink half-period in ticks (0 acts as 1)
//   cfg_duty      : PWM high count out of 2^DUTY_W
//   sync_restart  : clears prescaler, PWM counter and all channel phases
//   tick          : registered one-cycle pulse at TICK_HZ
//   led           : registered LED drive, one bit per channel
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 125_000_000,
    parameter int unsigned TICK_HZ    = 1000,
    parameter int unsigned N_CH       = 4,
    parameter int unsigned PER_W      = 16,
    parameter int unsigned DUTY_W     = 8,
    parameter int unsigned RST_PERIOD = 500
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_we,
    input  logic [ch_width(N_CH)-1:0]    cfg_ch,
    input  logic [1:0]                   cfg_mode,
    input  logic [PER_W-1:0]             cfg_period,
    input  logic [DUTY_W-1:0]            cfg_duty,
    input  logic                         sync_restart,
    output logic                         tick,
    output logic [N_CH-1:0]              led
);

    localparam int unsigned PS_TERM = presc_terminal(CLK_HZ, TICK_HZ);
    localparam int unsigned PS_W    = presc_width(CLK_HZ, TICK_HZ);
    localparam int unsigned CH_W    = ch_width(N_CH);

    logic [PS_W-1:0]   ps_cnt;
    logic [DUTY_W-1:0] pwm_cnt;

    // tick is registered: it rises in the cycle after the terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_cnt  <= '0;
            tick    <= 1'b0;
            pwm_cnt <= '0;
        end else if (sync_restart) begin
            ps_cnt  <= '0;
            tick    <= 1'b0;
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + DUTY_W'(1);
            if (ps_cnt == PS_W'(PS_TERM)) begin
                ps_cnt <= '0;
                tick   <= 1'b1;
            end else begin
                ps_cnt <= ps_cnt + PS_W'(1);
                tick   <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic ch_we;

        // Channel indices only go up to N_CH-1, so an out-of-range cfg_ch
        // matches no channel and the write is dropped.
        assign ch_we = cfg_we && (cfg_ch == CH_W'(i));

        led_channel #(
            .PER_W      (PER_W),
            .DUTY_W     (DUTY_W),
            .RST_PERIOD (RST_PERIOD)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .tick       (tick),
            .pwm_cnt    (pwm_cnt),
            .clear      (sync_restart),
            .we         (ch_we),
            .cfg_mode   (mode_e'(cfg_mode)),
            .cfg_period (cfg_period),
            .cfg_duty   (cfg_duty),
            .led        (led[i])
        );
    end

endmodule
